// File: rtl/instr_fetch_unit.sv
// Prefetching instruction fetch stage: issues ROM reads, buffers {pc, word} in a show-ahead FIFO.
// Optional performance counters (fetch_cnt, squash_cnt) are built when IFU_PERF_CNT_EN is defined.
module instr_fetch_unit #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Run,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] ir_data,
  output logic [15:0]       ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              redirect,
  input  logic [15:0]       redirect_pc,
  output logic [15:0]       fetch_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_cnt,
  output logic [15:0]       squash_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
  state_t state_q, state_d;

  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [15:0]       pc_mem   [DEPTH];
  logic              vld_p1;
  logic [15:0]       pc_p1;
  logic [CNT_W:0]    occupancy;
  logic              issue, push, pop;

  // Stage p0: issue a ROM read while FIFO slots plus the outstanding read leave room
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, vld_p1};
  assign issue     = Run & ~redirect & ~Reset & (occupancy < DEPTH_C);
  assign mem_rd    = issue;
  assign mem_addr  = fetch_pc[ADDR_W-1:0];

  // Stage p1: ROM response arrives; a redirect or reset in this cycle squashes it
  assign push     = vld_p1 & ~redirect & ~Reset;
  assign ir_valid = (count != '0);
  assign pop      = ir_valid & ir_ready;
  assign ir_data  = ir_valid ? data_mem[rd_ptr] : '0;
  assign ir_pc    = ir_valid ? pc_mem[rd_ptr]   : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = FETCH;
      FETCH:   if (!issue) state_d = IDLE;
      FLUSH:   state_d = Run ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
    if (redirect) state_d = FLUSH;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= IDLE;
      fetch_pc <= '0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      vld_p1   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= issue;
      if (redirect) begin
        fetch_pc <= redirect_pc;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (issue) fetch_pc <= fetch_pc + 16'd1;
        if (push)  wr_ptr   <= wr_ptr + 1'b1;
        if (pop)   rd_ptr   <= rd_ptr + 1'b1;
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (issue) pc_p1 <= fetch_pc;
    if (push) begin
      data_mem[wr_ptr] <= mem_q;
      pc_mem[wr_ptr]   <= pc_p1;
    end
  end

  assert property (@(posedge Clock) disable iff (Reset) !(push && count == FULL_C));

`ifdef IFU_PERF_CNT_EN
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  always_ff @(posedge Clock) begin
    if (Reset) begin
      fetch_cnt  <= '0;
      squash_cnt <= '0;
    end else begin
      if (push)     fetch_cnt  <= sat_add16(fetch_cnt, 16'd1);
      if (redirect) squash_cnt <= sat_add16(squash_cnt, 16'(occupancy));
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed steps plus random traffic against a queue-based reference model.
module tb_instr_fetch_unit;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 4;

  logic              Clock = 1'b0;
  logic              Reset, Run, mem_rd, ir_valid, ir_ready, redirect;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_q, ir_data;
  logic [15:0]       ir_pc, redirect_pc, fetch_pc;
`ifdef IFU_PERF_CNT_EN
  logic [15:0]       fetch_cnt, squash_cnt;
`endif

  instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .Clock(Clock), .Reset(Reset), .Run(Run),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_q(mem_q),
    .ir_data(ir_data), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_pc(fetch_pc)
`ifdef IFU_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .squash_cnt(squash_cnt)
`endif
  );

  always #5 Clock = ~Clock;

  logic [15:0] rom [32];
  always @(posedge Clock) if (mem_rd) mem_q <= rom[mem_addr];

  typedef struct packed {logic [15:0] pc; logic [15:0] data;} ent_t;
  ent_t        q[$];
  bit          m_pend;
  logic [15:0] m_pend_pc;
  logic [15:0] m_fpc;
  int          m_fetch, m_squash;
  int          n_assert = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pend   = 1'b0;
    m_fpc    = 16'h0000;
    m_fetch  = 0;
    m_squash = 0;
  endtask

  // Compare outputs for the current inputs, clock once, then advance the model.
  task automatic step();
    bit   e_issue;
    ent_t e;
    #1;
    e_issue = !Reset && Run && !redirect && (q.size() + int'(m_pend) < DEPTH);
    check("mem_rd", mem_rd, e_issue);
    if (e_issue) check("mem_addr", mem_addr, m_fpc[4:0]);
    check("fetch_pc", fetch_pc, m_fpc);
    check("ir_valid", ir_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("ir_pc", ir_pc, q[0].pc);
      check("ir_data", ir_data, q[0].data);
    end else begin
      check("ir_pc_idle", ir_pc, 0);
      check("ir_data_idle", ir_data, 0);
    end
`ifdef IFU_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, (m_fetch > 65535) ? 65535 : m_fetch);
    check("squash_cnt", squash_cnt, (m_squash > 65535) ? 65535 : m_squash);
`endif
    @(posedge Clock);
    if (Reset) begin
      model_reset();
    end else if (redirect) begin
      m_squash += q.size() + int'(m_pend);
      q.delete();
      m_pend = 1'b0;
      m_fpc  = redirect_pc;
    end else begin
      if (q.size() != 0 && ir_ready) void'(q.pop_front());
      if (m_pend) begin
        e.pc   = m_pend_pc;
        e.data = rom[m_pend_pc[4:0]];
        q.push_back(e);
        m_fetch++;
      end
      m_pend = e_issue;
      if (e_issue) begin
        m_pend_pc = m_fpc;
        m_fpc     = m_fpc + 16'd1;
      end
    end
    @(negedge Clock);
  endtask

  initial begin
    Reset = 1'b1; Run = 1'b0; ir_ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    for (int k = 0; k < 32; k++) rom[k] = 16'h1000 + 16'(k);
    @(posedge Clock);
    @(negedge Clock);
    model_reset();
    step();

    // streaming with decode always ready
    Reset = 1'b0; Run = 1'b1; ir_ready = 1'b1;
    repeat (12) step();

    // decode stalls: FIFO fills to DEPTH, then resumes
    ir_ready = 1'b0;
    repeat (8) step();
    ir_ready = 1'b1;
    repeat (6) step();

    // redirect with three buffered entries and one read in flight
    Reset = 1'b1; step();
    Reset = 1'b0; Run = 1'b1; ir_ready = 1'b0;
    repeat (4) step();
    redirect = 1'b1; redirect_pc = 16'h0014; step();
    redirect = 1'b0; ir_ready = 1'b1;
    repeat (8) step();

    // ROM address wrap and 16-bit fetch_pc wrap
    redirect = 1'b1; redirect_pc = 16'h001F; step();
    redirect = 1'b0;
    repeat (6) step();
    redirect = 1'b1; redirect_pc = 16'hFFFE; step();
    redirect = 1'b0;
    repeat (6) step();

    // Run low: outstanding response still lands, FIFO drains; redirect still applies
    ir_ready = 1'b0;
    repeat (3) step();
    Run = 1'b0; ir_ready = 1'b1;
    repeat (4) step();
    redirect = 1'b1; redirect_pc = 16'h0100; step();
    redirect = 1'b0;
    repeat (2) step();
    Run = 1'b1;
    repeat (4) step();

    // reset the cycle after an issue discards the response
    Reset = 1'b1; step();
    Reset = 1'b0; Run = 1'b1; ir_ready = 1'b0; step();
    Reset = 1'b1; Run = 1'b0; step();
    Reset = 1'b0;
    repeat (3) step();

    // random traffic with random ROM contents
    Reset = 1'b1;
    for (int k = 0; k < 32; k++) rom[k] = 16'($urandom);
    step();
    repeat (600) begin
      Reset       = ($urandom_range(0, 99) == 0);
      Run         = ($urandom_range(0, 9) < 8);
      ir_ready    = ($urandom_range(0, 9) < 7);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 16'($urandom);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Prefetching instruction fetch stage that sits directly upstream of the processor's IR/decode.
- Owns the fetch PC and drives the synchronous instruction ROM. The ROM has 1-cycle read latency and is 32 x 16.
- Buffers fetched words, with their PCs, in a small FIFO and presents them to decode over a valid/ready handshake.
- Flushes the buffer and restarts fetch on a taken branch or PC write (redirect).

Parameters:
- ADDR_W, 5: instruction ROM address width; mem_addr = fetch_pc[ADDR_W-1:0].
- DATA_W, 16: instruction word width.
- DEPTH, 4: prefetch FIFO entries; must be a power of 2, minimum 2.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  fetch enable; when low, no new ROM reads are issued.
- mem_addr  out  ADDR_W  ROM read address.
- mem_rd  out  1  ROM read strobe; mem_q is valid in the following cycle.
- mem_q  in  DATA_W  ROM read data.
- ir_data  out  DATA_W  instruction at the FIFO head.
- ir_pc  out  16  PC of ir_data.
- ir_valid  out  1  FIFO head valid.
- ir_ready  in  1  decode accepts the head this cycle.
- redirect  in  1  branch taken / PC written; single-cycle pulse.
- redirect_pc  in  16  new fetch PC.
- fetch_pc  out  16  PC of the next read to issue.

Behaviour:
Reset and fill level
- Reset (sync, high) forces: fetch_pc=0, FIFO empty (count=0, pointers 0), ir_valid=0, ir_data=0, ir_pc=0, mem_rd=0, inflight=0.
- Reset asserted mid-operation discards the FIFO and any in-flight response; nothing is pushed in the following cycle.

Issue
- Issue condition: Run & ~redirect & (count + inflight + 1 <= DEPTH).
- On issue: mem_rd=1, mem_addr=fetch_pc[ADDR_W-1:0], fetch_pc <= fetch_pc+1. inflight <= 1 with tag inflight_pc=fetch_pc.
- Otherwise mem_rd=0.
- fetch_pc is 16-bit and wraps 0xFFFF->0x0000.
- mem_addr wraps every 2^ADDR_W words; 31->0 with defaults.

Response and FIFO
- Response: in the cycle after an issue, {inflight_pc, mem_q} is pushed unless squashed.
- FIFO is show-ahead: ir_valid = (count != 0), with ir_data/ir_pc driven from the head.
- Pop on ir_valid & ir_ready. Simultaneous push and pop leaves count unchanged.
- Pushing when full is impossible by the issue condition. Any attempt is an assertion failure.
- Latency: issue at cycle t -> push at the end of t+1 -> ir_valid at t+2 (FIFO empty, no redirect).
- Steady state with ir_ready=1: one instruction per cycle.

Redirect (highest priority after Reset)
- Same cycle: FIFO cleared (count=0), the in-flight response marked squashed, no issue, fetch_pc <= redirect_pc.
- A pop handshaking in the redirect cycle completes for the consumer. It is not counted again.
- First issue from redirect_pc happens the next cycle if Run=1. ir_valid returns 2 cycles after that issue.
- Redirect while Run=0: fetch_pc is still updated and the FIFO still flushed.

Run=0
- Stops issuing only.
- An outstanding response is still pushed.
- The FIFO continues to drain.

FSM
- IDLE (Run=0, or Run=1 with FIFO/inflight full; no issue).
- FETCH (issuing).
- FLUSH (one cycle, entered on redirect, no issue; goes to FETCH if Run else IDLE).
- IDLE->FETCH when the issue condition holds.
- Reset forces IDLE.

Optional Feature:
- Macro IFU_PERF_CNT_EN.
- When defined:
  - Adds outputs fetch_cnt[15:0] (pushes, squashed responses excluded) and squash_cnt[15:0] (squashed responses plus FIFO entries discarded by redirect).
  - Both counters are cleared by Reset and saturate at 0xFFFF.
- When undefined: the ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- Reset, Run=1, ir_ready=1, ROM[k]=0x1000+k -> mem_rd high from cycle 1. ir_valid first high 2 cycles after the first issue with ir_pc=0, ir_data=0x1000. Then ir_pc increments by 1 every cycle.
- ir_ready=0, Run=1 -> exactly DEPTH=4 reads issued. count=4, mem_rd stays 0, ir_pc holds 0. Raising ir_ready resumes reads one per pop.
- Redirect with redirect_pc=0x0014 while count=3 and one read in flight -> ir_valid=0 next cycle. Next issue has mem_addr=0x14. The next instruction presented has ir_pc=0x0014, and the squashed PC is never presented.
- fetch_pc=0x001F, Run=1 -> mem_addr sequence 0x1F, 0x00. ir_pc values 0x001F, 0x0020.
- Reset asserted the cycle after an issue with ir_ready=0 -> ir_valid=0 and count=0 next cycle, and the ROM response is not pushed.
- With IFU_PERF_CNT_EN defined: 5 fetches, then a redirect with 2 FIFO entries and 1 read in flight -> squash_cnt=3 and fetch_cnt=5 (the squashed read excluded).
